// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the instruction BSRAM.
// Receives framed bytes (A5, LEN_HI, LEN_LO, N x {hi,lo}, CSUM), writes each
// 16-bit word to consecutive BSRAM addresses from 0, and holds the CPU in
// reset until a frame with a matching checksum completes.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   rx_data, rx_valid   byte input, one-cycle strobe, always accepted
//   mem_ad/din/wre      BSRAM write port (wre is a one-cycle strobe)
//   cpu_hold            keep CPU in reset and mux mem_ad over the PC
//   busy, done, err     frame in progress / last frame good / last frame bad
module prog_loader #(
    parameter int ADDR_W         = 11,
    parameter int TIMEOUT_CYCLES = 2_700_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [15:0]       mem_din,
    output logic              mem_wre,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int         TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            state, state_n;
    logic [15:0]       len, len_n;
    logic [7:0]        hi, hi_n;
    logic [7:0]        sum, sum_n;
    logic [ADDR_W:0]   wcnt, wcnt_n;        // one extra bit so N = 2^ADDR_W fits
    logic [TO_W-1:0]   to_cnt, to_cnt_n;
    logic [ADDR_W-1:0] mem_ad_n;
    logic [15:0]       mem_din_n;
    logic              mem_wre_n, cpu_hold_n, done_n, err_n;

    logic              in_frame, expire;
    logic [15:0]       len_new;
    logic [ADDR_W:0]   wcnt_inc;

    assign in_frame = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA_HI) ||
                      (state == S_DATA_LO) || (state == S_CSUM);
    // A byte on the expiry cycle takes priority over the timeout.
    assign expire   = in_frame && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign len_new  = {len[15:8], rx_data};
    assign wcnt_inc = wcnt + 1'b1;

    always_comb begin
        state_n    = state;
        len_n      = len;
        hi_n       = hi;
        sum_n      = sum;
        wcnt_n     = wcnt;
        mem_ad_n   = mem_ad;
        mem_din_n  = mem_din;
        mem_wre_n  = 1'b0;
        cpu_hold_n = cpu_hold;
        done_n     = done;
        err_n      = err;
        to_cnt_n   = (in_frame && !rx_valid && !expire) ? to_cnt + 1'b1 : '0;

        if (rx_valid) begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (rx_data == SYNC) begin
                        state_n    = S_LEN_HI;
                        cpu_hold_n = 1'b1;
                        done_n     = 1'b0;
                        err_n      = 1'b0;
                        wcnt_n     = '0;
                        sum_n      = '0;
                    end
                end
                S_LEN_HI: begin
                    len_n[15:8] = rx_data;
                    state_n     = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_n = len_new;
                    if (32'(len_new) > (32'd1 << ADDR_W)) begin
                        state_n = S_ERR;
                        err_n   = 1'b1;
                    end else if (len_new == 16'd0) begin
                        state_n = S_CSUM;
                    end else begin
                        state_n = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    hi_n    = rx_data;
                    sum_n   = sum + rx_data;
                    state_n = S_DATA_LO;
                end
                S_DATA_LO: begin
                    sum_n     = sum + rx_data;
                    mem_wre_n = 1'b1;
                    mem_ad_n  = wcnt[ADDR_W-1:0];
                    mem_din_n = {hi, rx_data};
                    wcnt_n    = wcnt_inc;
                    state_n   = (32'(wcnt_inc) == 32'(len)) ? S_CSUM : S_DATA_HI;
                end
                S_CSUM: begin
                    if (rx_data == sum) begin
                        state_n    = S_DONE;
                        cpu_hold_n = 1'b0;
                        done_n     = 1'b1;
                    end else begin
                        state_n = S_ERR;
                        err_n   = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end else if (expire) begin
            state_n = S_ERR;
            err_n   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            len      <= '0;
            hi       <= '0;
            sum      <= '0;
            wcnt     <= '0;
            to_cnt   <= '0;
            mem_ad   <= '0;
            mem_din  <= '0;
            mem_wre  <= 1'b0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            len      <= len_n;
            hi       <= hi_n;
            sum      <= sum_n;
            wcnt     <= wcnt_n;
            to_cnt   <= to_cnt_n;
            mem_ad   <= mem_ad_n;
            mem_din  <= mem_din_n;
            mem_wre  <= mem_wre_n;
            cpu_hold <= cpu_hold_n;
            done     <= done_n;
            err      <= err_n;
            busy     <= (state_n == S_LEN_HI) || (state_n == S_LEN_LO) ||
                        (state_n == S_DATA_HI) || (state_n == S_DATA_LO) ||
                        (state_n == S_CSUM);
        end
    end

endmodule
